// File: rtl/mio_bus_arbiter_if.sv
// Shared memory/IO bus bundle: CPU data port, DMA requester, memory port.
// master: arbiter side.  slave: requesters plus memory side.
interface mio_bus_arbiter_if;
    // CPU data port
    logic        CPU_MIO;
    logic        MemRW;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        MIO_ready;
    logic [31:0] cpu_rdata;
    // DMA / debug requester
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    // fixed-latency memory port
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        input  CPU_MIO, MemRW, cpu_addr, cpu_wdata,
        output MIO_ready, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output CPU_MIO, MemRW, cpu_addr, cpu_wdata,
        input  MIO_ready, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter and wait-state sequencer sharing one fixed-latency
// memory port between the CPU data port and a DMA/debug requester.
// Ports: clk, rst (sync, active-high), bus (mio_bus_arbiter_if.master).
// Parameter WAIT_CYCLES (>=1): memory access latency in cycles.
module mio_bus_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    mio_bus_arbiter_if.master bus
);

    localparam int CW_RAW = $clog2(WAIT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            last_q;
    logic [CW-1:0]   cnt_q;
    logic            own_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     crd_q;
    logic [31:0]     drd_q;

    logic            cpu_cand;
    logic            dma_cand;
    logic            grant;
    logic            grant_own;
    logic            done;

    // Next-state and arbitration. In RESP the owner being acked still
    // holds its request, so it is masked out of this cycle's contest.
    always_comb begin
        state_d   = state_q;
        cpu_cand  = 1'b0;
        dma_cand  = 1'b0;
        grant     = 1'b0;
        grant_own = OWN_CPU;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cpu_cand = bus.CPU_MIO;
                dma_cand = bus.dma_req;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cpu_cand = bus.CPU_MIO && (own_q != OWN_CPU);
                dma_cand = bus.dma_req && (own_q != OWN_DMA);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cpu_cand || dma_cand) begin
            grant   = 1'b1;
            state_d = S_ACCESS;
            if (cpu_cand && dma_cand)
                grant_own = ~last_q;
            else
                grant_own = dma_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Access bundle is latched at grant so the memory sees a stable
    // request for the whole latency regardless of requester inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= OWN_DMA;
            cnt_q   <= '0;
            own_q   <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crd_q   <= '0;
            drd_q   <= '0;
        end else begin
            if (grant) begin
                own_q   <= grant_own;
                cnt_q   <= CNT_LOAD;
                if (grant_own == OWN_DMA) begin
                    we_q    <= bus.dma_we;
                    addr_q  <= bus.dma_addr;
                    wdata_q <= bus.dma_wdata;
                end else begin
                    we_q    <= bus.MemRW;
                    addr_q  <= bus.cpu_addr;
                    wdata_q <= bus.cpu_wdata;
                end
            end else if (state_q == S_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) begin
                last_q <= own_q;
                if (!we_q) begin
                    if (own_q == OWN_DMA)
                        drd_q <= bus.mem_rdata;
                    else
                        crd_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = (state_q == S_ACCESS);
    assign bus.mem_we    = (state_q == S_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.MIO_ready = (state_q == S_RESP) && (own_q == OWN_CPU);
    assign bus.dma_ack   = (state_q == S_RESP) && (own_q == OWN_DMA);
    assign bus.cpu_rdata = crd_q;
    assign bus.dma_rdata = drd_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: three instances (W=1,2,3), a cycle-timeline
// reference model, per-cycle comparison plus directed literal checks.
module tb_mio_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon3 = 1'b0;
    bit   seen3 = 1'b0;

    always #5 clk = ~clk;

    mio_bus_arbiter_if i1 ();
    mio_bus_arbiter_if i2 ();
    mio_bus_arbiter_if i3 ();

    mio_bus_arbiter #(.WAIT_CYCLES(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
    mio_bus_arbiter #(.WAIT_CYCLES(2)) d2 (.clk(clk), .rst(rst), .bus(i2));
    mio_bus_arbiter #(.WAIT_CYCLES(3)) d3 (.clk(clk), .rst(rst), .bus(i3));

    // Model: each transaction is a grant cycle; access occupies the next
    // W cycles and the ack lands on the cycle after that.
    bit          mv     [3];
    bit          m_act  [3];
    bit          m_own  [3];
    int          m_start[3];
    int          m_ack  [3];
    bit          m_aown [3];
    bit          m_last [3];
    bit          m_we   [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_wd   [3];
    logic [31:0] m_crd  [3];
    logic [31:0] m_drd  [3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int k, input int w, input logic r,
                        input logic creq, input logic cwe,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dreq, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] mrd);
        int  cur;
        bit  in_acc;
        bit  cq;
        bit  dq;
        bit  pick;
        cur = cyc;
        if (r) begin
            mv[k] = 1; m_act[k] = 0; m_ack[k] = -1; m_last[k] = 1;
            m_own[k] = 0; m_aown[k] = 0; m_start[k] = 0; m_we[k] = 0;
            m_addr[k] = 0; m_wd[k] = 0; m_crd[k] = 0; m_drd[k] = 0;
            return;
        end
        if (!mv[k]) return;
        in_acc = m_act[k] && cur >= m_start[k] && cur <= m_start[k] + w - 1;
        if (in_acc) begin
            if (cur == m_start[k] + w - 1) begin
                if (!m_we[k]) begin
                    if (m_own[k]) m_drd[k] = mrd;
                    else m_crd[k] = mrd;
                end
                m_last[k] = m_own[k];
                m_ack[k]  = cur + 1;
                m_aown[k] = m_own[k];
                m_act[k]  = 0;
            end
        end else begin
            cq = creq && !(cur == m_ack[k] && m_aown[k] == 0);
            dq = dreq && !(cur == m_ack[k] && m_aown[k] == 1);
            if (cq || dq) begin
                pick = (cq && dq) ? !m_last[k] : dq;
                m_act[k] = 1; m_start[k] = cur + 1; m_own[k] = pick;
                m_we[k]   = pick ? dwe : cwe;
                m_addr[k] = pick ? da : ca;
                m_wd[k]   = pick ? dd : cd;
            end
        end
    endtask

    task automatic cmp(input int k, input int w, input string p,
                       input logic en, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic bz, input logic rdy, input logic ack,
                       input logic [31:0] crd, input logic [31:0] drd);
        bit acc;
        bit ak;
        if (!mv[k]) return;
        acc = m_act[k] && cyc >= m_start[k] && cyc <= m_start[k] + w - 1;
        ak  = (cyc == m_ack[k]);
        chk({p, "_mem_en"}, 32'(en), 32'(acc));
        chk({p, "_mem_we"}, 32'(we), 32'(acc && m_we[k]));
        chk({p, "_mem_addr"}, a, m_addr[k]);
        chk({p, "_mem_wdata"}, wd, m_wd[k]);
        chk({p, "_busy"}, 32'(bz), 32'(acc || ak));
        chk({p, "_MIO_ready"}, 32'(rdy), 32'(ak && !m_aown[k]));
        chk({p, "_dma_ack"}, 32'(ack), 32'(ak && m_aown[k]));
        chk({p, "_cpu_rdata"}, crd, m_crd[k]);
        chk({p, "_dma_rdata"}, drd, m_drd[k]);
    endtask

    always @(posedge clk) begin
        step(0, 1, rst, i1.CPU_MIO, i1.MemRW, i1.cpu_addr, i1.cpu_wdata,
             i1.dma_req, i1.dma_we, i1.dma_addr, i1.dma_wdata, i1.mem_rdata);
        step(1, 2, rst, i2.CPU_MIO, i2.MemRW, i2.cpu_addr, i2.cpu_wdata,
             i2.dma_req, i2.dma_we, i2.dma_addr, i2.dma_wdata, i2.mem_rdata);
        step(2, 3, rst, i3.CPU_MIO, i3.MemRW, i3.cpu_addr, i3.cpu_wdata,
             i3.dma_req, i3.dma_we, i3.dma_addr, i3.dma_wdata, i3.mem_rdata);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        cmp(0, 1, "w1", i1.mem_en, i1.mem_we, i1.mem_addr, i1.mem_wdata,
            i1.busy, i1.MIO_ready, i1.dma_ack, i1.cpu_rdata, i1.dma_rdata);
        cmp(1, 2, "w2", i2.mem_en, i2.mem_we, i2.mem_addr, i2.mem_wdata,
            i2.busy, i2.MIO_ready, i2.dma_ack, i2.cpu_rdata, i2.dma_rdata);
        cmp(2, 3, "w3", i3.mem_en, i3.mem_we, i3.mem_addr, i3.mem_wdata,
            i3.busy, i3.MIO_ready, i3.dma_ack, i3.cpu_rdata, i3.dma_rdata);
        if (mon3 && i3.MIO_ready) seen3 = 1'b1;
    end

    // Lands on the negedge of relative cycle n (cycle 0 = base).
    task automatic at(input int n);
        @(negedge clk);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic start();
        base = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        i1.CPU_MIO = 0; i1.MemRW = 0; i1.cpu_addr = 0; i1.cpu_wdata = 0;
        i1.dma_req = 0; i1.dma_we = 0; i1.dma_addr = 0; i1.dma_wdata = 0;
        i1.mem_rdata = 0;
        i2.CPU_MIO = 0; i2.MemRW = 0; i2.cpu_addr = 0; i2.cpu_wdata = 0;
        i2.dma_req = 0; i2.dma_we = 0; i2.dma_addr = 0; i2.dma_wdata = 0;
        i2.mem_rdata = 0;
        i3.CPU_MIO = 0; i3.MemRW = 0; i3.cpu_addr = 0; i3.cpu_wdata = 0;
        i3.dma_req = 0; i3.dma_we = 0; i3.dma_addr = 0; i3.dma_wdata = 0;
        i3.mem_rdata = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", 32'(i2.mem_en), 32'h0);
        chk("rst_busy", 32'(i2.busy), 32'h0);
        chk("rst_ready", 32'(i2.MIO_ready), 32'h0);
        chk("rst_mem_addr", i2.mem_addr, 32'h0);
        chk("rst_cpu_rdata", i2.cpu_rdata, 32'h0);
        rst = 0;

        // CPU load, W=2
        i2.CPU_MIO = 1; i2.MemRW = 0; i2.cpu_addr = 32'h10;
        i2.mem_rdata = 32'hDEAD_BEEF;
        start();
        at(1);
        chk("t1_en_c1", 32'(i2.mem_en), 32'h1);
        chk("t1_addr_c1", i2.mem_addr, 32'h10);
        chk("t1_we_c1", 32'(i2.mem_we), 32'h0);
        at(2);
        chk("t1_en_c2", 32'(i2.mem_en), 32'h1);
        chk("t1_rdy_c2", 32'(i2.MIO_ready), 32'h0);
        at(3);
        chk("t1_rdy_c3", 32'(i2.MIO_ready), 32'h1);
        chk("t1_rdata", i2.cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_en_c3", 32'(i2.mem_en), 32'h0);
        i2.CPU_MIO = 0;
        at(4);
        chk("t1_rdy_c4", 32'(i2.MIO_ready), 32'h0);
        chk("t1_busy_c4", 32'(i2.busy), 32'h0);

        // DMA read then DMA write, W=1
        i1.dma_req = 1; i1.dma_we = 0; i1.dma_addr = 32'h80;
        i1.mem_rdata = 32'hCAFE_F00D;
        start();
        at(2);
        chk("t2r_ack", 32'(i1.dma_ack), 32'h1);
        chk("t2r_rdata", i1.dma_rdata, 32'hCAFE_F00D);
        i1.dma_req = 0;
        at(3);
        i1.dma_req = 1; i1.dma_we = 1; i1.dma_addr = 32'h100;
        i1.dma_wdata = 32'h1234_5678; i1.mem_rdata = 32'h5555_5555;
        start();
        at(1);
        chk("t2w_we", 32'(i1.mem_we), 32'h1);
        chk("t2w_wdata", i1.mem_wdata, 32'h1234_5678);
        chk("t2w_addr", i1.mem_addr, 32'h100);
        at(2);
        chk("t2w_ack", 32'(i1.dma_ack), 32'h1);
        chk("t2w_we_off", 32'(i1.mem_we), 32'h0);
        chk("t2w_rdata_kept", i1.dma_rdata, 32'hCAFE_F00D);
        i1.dma_req = 0; i1.dma_we = 0;
        at(3);

        // W=1 CPU load, request dropped after cycle 0
        i1.CPU_MIO = 1; i1.MemRW = 0; i1.cpu_addr = 32'h44;
        i1.mem_rdata = 32'h0BAD_F00D;
        start();
        at(1);
        i1.CPU_MIO = 0;
        chk("t6_en", 32'(i1.mem_en), 32'h1);
        at(2);
        chk("t6_rdy", 32'(i1.MIO_ready), 32'h1);
        chk("t6_rdata", i1.cpu_rdata, 32'h0BAD_F00D);
        at(3);
        chk("t6_rdy_off", 32'(i1.MIO_ready), 32'h0);

        // Both held, W=2, from reset
        rst = 1;
        @(negedge clk);
        rst = 0;
        i2.CPU_MIO = 1; i2.cpu_addr = 32'h200;
        i2.dma_req = 1; i2.dma_we = 0; i2.dma_addr = 32'h300;
        i2.mem_rdata = 32'h1111_0000;
        start();
        at(1);
        chk("t3_addr_cpu", i2.mem_addr, 32'h200);
        at(3);
        chk("t3_rdy3", 32'(i2.MIO_ready), 32'h1);
        chk("t3_ack3", 32'(i2.dma_ack), 32'h0);
        at(4);
        chk("t3_addr_dma", i2.mem_addr, 32'h300);
        at(6);
        chk("t3_ack6", 32'(i2.dma_ack), 32'h1);
        chk("t3_rdy6", 32'(i2.MIO_ready), 32'h0);
        at(9);
        chk("t3_rdy9", 32'(i2.MIO_ready), 32'h1);
        i2.CPU_MIO = 0; i2.dma_req = 0;
        at(12);

        // Address change mid-access, W=2
        i2.CPU_MIO = 1; i2.cpu_addr = 32'h20;
        start();
        at(1);
        i2.cpu_addr = 32'h40;
        chk("t4_addr_c1", i2.mem_addr, 32'h20);
        at(2);
        chk("t4_addr_c2", i2.mem_addr, 32'h20);
        at(3);
        chk("t4_rdy", 32'(i2.MIO_ready), 32'h1);
        i2.CPU_MIO = 0;
        at(4);

        // Reset during W=3 access
        seen3 = 0; mon3 = 1;
        i3.CPU_MIO = 1; i3.MemRW = 0; i3.cpu_addr = 32'h30;
        i3.mem_rdata = 32'h3333_3333;
        start();
        at(1);
        chk("t5_en_c1", 32'(i3.mem_en), 32'h1);
        at(2);
        rst = 1;
        at(3);
        chk("t5_en_rst", 32'(i3.mem_en), 32'h0);
        chk("t5_busy_rst", 32'(i3.busy), 32'h0);
        rst = 0; i3.CPU_MIO = 0;
        at(9);
        chk("t5_no_ready", 32'(seen3), 32'h0);
        mon3 = 0;
        i3.CPU_MIO = 1; i3.cpu_addr = 32'h34;
        i3.dma_req = 1; i3.dma_addr = 32'h38; i3.mem_rdata = 32'h7777_0000;
        start();
        at(4);
        chk("t5_tie_cpu", 32'(i3.MIO_ready), 32'h1);
        chk("t5_tie_dma", 32'(i3.dma_ack), 32'h0);
        i3.CPU_MIO = 0;
        at(8);
        chk("t5_dma_ack", 32'(i3.dma_ack), 32'h1);
        i3.dma_req = 0;
        at(11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-requester arbiter and wait-state sequencer for the shared memory/IO bus behind the single-cycle CPU. It shares one fixed-latency memory port between the CPU data port (`CPU_MIO`/`MemRW`/`Addr_out`/`Data_out`) and a DMA/debug requester. It generates the CPU's `MIO_ready` stall handshake and a DMA acknowledge. Grants alternate round-robin; each access is latched at grant and held stable for the whole memory latency.

## Interface
- `WAIT_CYCLES`, default 2: memory access latency in cycles; legal range ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `CPU_MIO` input 1: CPU data request, held until `MIO_ready`.
- `MemRW` input 1: CPU write enable (1 = store).
- `cpu_addr` input 32: CPU byte address (`Addr_out`).
- `cpu_wdata` input 32: CPU store data (`Data_out`).
- `MIO_ready` output 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` output 32: load data, valid while `MIO_ready`=1.
- `dma_req` input 1: DMA request, held until `dma_ack`.
- `dma_we` input 1: DMA write enable.
- `dma_addr` input 32: DMA address.
- `dma_wdata` input 32: DMA write data.
- `dma_ack` output 1: one-cycle completion pulse to DMA.
- `dma_rdata` output 32: read data, valid while `dma_ack`=1.
- `mem_en` output 1: memory access active.
- `mem_we` output 1: memory write strobe.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory read data, valid in the last access cycle.
- `busy` output 1: high in ACCESS and RESP.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: drive memory for `WAIT_CYCLES` cycles.
  - RESP: one-cycle acknowledge, plus re-arbitrate.
- Arbitration is round-robin via a 1-bit `last` pointer.
  - With both requests high, grant the requester ≠ `last`.
  - With a single request, grant it.
  - After reset `last`=DMA, so the CPU wins the first tie.
- At grant, latch owner, we, addr and wdata into internal registers. Load the down-counter with `WAIT_CYCLES-1`; counter width is `$clog2(WAIT_CYCLES+1)`, minimum 1 bit.
- ACCESS:
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched registers, constant for the whole access.
  - Requester inputs are ignored.
  - When the counter reaches 0: capture `mem_rdata` into the owner's rdata register, update `last`=owner, go to RESP.
- RESP:
  - Pulse the owner's `MIO_ready` or `dma_ack`.
  - The served requester is excluded from this cycle's arbitration, because its req is still high during its ack cycle.
  - If the other requester is requesting, grant it and go straight to ACCESS; otherwise go to IDLE.
- `cpu_rdata`/`dma_rdata` hold their last captured value until the next read by that requester. Writes leave them unchanged.
- Requester protocol: req, we, addr and wdata must stay stable until ack. If req drops mid-access, the access still completes and the ack is still pulsed.
- `mem_we` is never 1 while `mem_en`=0.

## Timing
- Reset values:
  - FSM=IDLE, `last`=DMA, counter=0.
  - `MIO_ready`=0, `dma_ack`=0, `mem_en`=0, `mem_we`=0, `busy`=0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata` and `dma_rdata` all =0.
- Reset mid-access aborts: next cycle is IDLE with all outputs at reset values; no ack is issued.
- Single access with the request sampled high in IDLE at edge 0:
  - `mem_en`=1 in cycles 1..W.
  - Read data sampled at the end of cycle W.
  - Ack high in cycle W+1.
  - Back in IDLE at W+2, unless chained.
- Latency from request to ack is W+1 cycles. With W=1: request at cycle 0, `mem_en` in cycle 1, ack in cycle 2.
- Chained access (other requester waiting during RESP): its ACCESS begins at W+2, so the bus carries one dead cycle per transaction.
- A same requester re-requesting immediately after ack is served no earlier than the cycle after RESP, from IDLE.
- Simultaneous requests in IDLE: the winner is ACK'd at W+1; the loser is granted in that RESP cycle and ACK'd at 2W+2.
- Outputs are registered state decodes; there is no combinational path from req inputs to ack outputs.

## Test plan
- Reset then single CPU load, W=2, addr=0x0000_0010, memory returns 0xDEAD_BEEF:
  - `mem_en` high in cycles 1–2 with `mem_addr`=0x10 and `mem_we`=0.
  - `MIO_ready`=1 only in cycle 3 with `cpu_rdata`=0xDEAD_BEEF.
- DMA write, W=1, addr=0x100, data=0x1234_5678:
  - `mem_we`=1 and `mem_wdata`=0x1234_5678 for one cycle.
  - `dma_ack` pulses in cycle 2.
  - `dma_rdata` is unchanged.
- Both requests held high continuously after reset, W=2:
  - Grants alternate CPU, DMA, CPU…
  - Acks land at cycles 3, 6, 9; no requester is served twice consecutively.
- CPU changes `cpu_addr` from 0x20 to 0x40 in the middle of an access: `mem_addr` stays 0x20 for the full access.
- `rst` asserted in cycle 2 of a W=3 access:
  - Next cycle: `mem_en`=0 and `busy`=0.
  - No `MIO_ready` is ever pulsed.
  - The next tie is granted to the CPU.
- W=1 CPU load where `CPU_MIO` drops after cycle 0: the access still completes and `MIO_ready` pulses in cycle 2.
